// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi_timer register bank: register indices
// within a channel's 4-word window and bit positions inside TCON.
package multi_timer_pkg;

    localparam logic [1:0] REG_TH   = 2'd0;
    localparam logic [1:0] REG_TL   = 2'd1;
    localparam logic [1:0] REG_TCON = 2'd2;
    localparam logic [1:0] REG_PSC  = 2'd3;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_IF = 2;
    localparam int TCON_OS = 3;

endpackage

// File: rtl/timer_channel.sv
// One up-counting timer channel: reload (TH), live count (TL), control/flags
// (TCON) and, when MULTI_TIMER_PRESCALE_EN is defined, a prescaler (PSC).
// Writes to TL or TCON hold off this channel's tick for that cycle so the
// written value is what lands in the register.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PSC_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_th,
    input  logic        we_tl,
    input  logic        we_tcon,
    input  logic        we_psc,
    input  logic [31:0] write_data,
    input  logic [1:0]  reg_sel,
    output logic [31:0] reg_rdata,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] th;
    logic [CNT_W-1:0] tl;
    logic             en;
    logic             ie;
    logic             if_flag;
    logic             os;
    logic             tick_gate;
    logic             tick;
    logic             overflow;
    logic [CNT_W-1:0] wr_cnt;

    assign wr_cnt = write_data[CNT_W-1:0];

`ifdef MULTI_TIMER_PRESCALE_EN
    localparam logic [PSC_W-1:0] PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

    logic [PSC_W-1:0] psc;
    logic [PSC_W-1:0] pcnt;

    assign tick_gate = (pcnt == psc);

    // Prescale divisor register and its free-running counter; the counter
    // restarts on a match, while disabled, or when TL/PSC is rewritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            psc  <= '0;
            pcnt <= '0;
        end else begin
            if (we_psc)
                psc <= write_data[PSC_W-1:0];
            if (!en || we_tl || we_psc || tick_gate)
                pcnt <= '0;
            else
                pcnt <= pcnt + PSC_ONE;
        end
    end
`else
    localparam int UNUSED_PSC_W = PSC_W;
    logic unused_we_psc;

    assign unused_we_psc = we_psc;
    assign tick_gate     = 1'b1;
`endif

    assign tick     = en && tick_gate && !we_tl && !we_tcon;
    assign overflow = tick && (tl == '1);

    // Reload and count registers; a TH write on the overflow edge reloads
    // TL with the value being written rather than the stale TH.
    always_ff @(posedge clk) begin
        if (reset) begin
            th <= '0;
            tl <= '0;
        end else begin
            if (we_th)
                th <= wr_cnt;
            if (we_tl)
                tl <= wr_cnt;
            else if (overflow)
                tl <= we_th ? wr_cnt : th;
            else if (tick)
                tl <= tl + CNT_ONE;
        end
    end

    // Control bits; IF is sticky, write-1-to-clear, and a set beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            if_flag <= 1'b0;
            os      <= 1'b0;
        end else begin
            if (we_tcon) begin
                en <= write_data[TCON_EN];
                ie <= write_data[TCON_IE];
                os <= write_data[TCON_OS];
            end else if (overflow && os) begin
                en <= 1'b0;
            end
            if (overflow && ie)
                if_flag <= 1'b1;
            else if (we_tcon && write_data[TCON_IF])
                if_flag <= 1'b0;
        end
    end

    // Register read mux, zero-extended to the 32-bit bus.
    always_comb begin
        reg_rdata = '0;
        case (reg_sel)
            REG_TH:   reg_rdata[CNT_W-1:0] = th;
            REG_TL:   reg_rdata[CNT_W-1:0] = tl;
            REG_TCON: reg_rdata[3:0]       = {os, if_flag, ie, en};
            default: begin
`ifdef MULTI_TIMER_PRESCALE_EN
                reg_rdata[PSC_W-1:0] = psc;
`endif
            end
        endcase
    end

    assign irq = if_flag & ie;

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped bank of NUM_CH timer channels on the data-memory bus.
// Word address = {channel, reg[1:0]}; unmapped channels read 0 and ignore
// writes. irq is the OR of every channel's (IF & IE).
// Optional feature macro: MULTI_TIMER_PRESCALE_EN (per-channel prescaler).
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int CNT_W  = 32,
    parameter  int PSC_W  = 16,
    localparam int ADDR_W = $clog2(NUM_CH) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              irq
);

    localparam int CH_W = (ADDR_W > 2) ? (ADDR_W - 2) : 1;

    logic [CH_W-1:0]   chan;
    logic [1:0]        reg_idx;
    logic [31:0]       ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] ch_irq;

    assign reg_idx = address[1:0];

    generate
        if (ADDR_W > 2) begin : g_chan_wide
            assign chan = address[ADDR_W-1:2];
        end else begin : g_chan_single
            assign chan = '0;
        end
    endgenerate

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            logic ch_wr;

            assign ch_wr = mem_write && (chan == CH_W'(g));

            timer_channel #(
                .CNT_W (CNT_W),
                .PSC_W (PSC_W)
            ) u_channel (
                .clk        (clk),
                .reset      (reset),
                .we_th      (ch_wr && (reg_idx == REG_TH)),
                .we_tl      (ch_wr && (reg_idx == REG_TL)),
                .we_tcon    (ch_wr && (reg_idx == REG_TCON)),
                .we_psc     (ch_wr && (reg_idx == REG_PSC)),
                .write_data (write_data),
                .reg_sel    (reg_idx),
                .reg_rdata  (ch_rdata[g]),
                .irq        (ch_irq[g])
            );
        end
    endgenerate

    // Bus read mux: only a strobed read of a mapped channel drives data.
    always_comb begin
        read_data = '0;
        if (mem_read) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (chan == CH_W'(c))
                    read_data = ch_rdata[c];
            end
        end
    end

    assign irq = |ch_irq;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer (5 channels so that channel indices
// 5..7 are unmapped). Each scenario pushes a script of bus writes and
// expected reads into a queue; reads are popped and compared as the DUT
// answers. One bus operation per clock, driven at the falling edge.
module tb_multi_timer;

    localparam int NCH = 5;
    localparam int AW  = $clog2(NCH) + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_read = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] address = '0;
    logic [31:0]   write_data = '0;
    logic [31:0]   read_data;
    logic          irq;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] a;
        logic [31:0]   v;
        logic          q;
        bit            ck_q;
        string         nm;
    } step_t;

    step_t sb[$];

    multi_timer #(
        .NUM_CH (NCH),
        .CNT_W  (32),
        .PSC_W  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    function automatic void push_w(input int ch, input int r, input logic [31:0] v);
        step_t s;
        s.is_wr = 1'b1; s.a = AW'(ch * 4 + r); s.v = v;
        s.q = 1'b0; s.ck_q = 1'b0; s.nm = "wr";
        sb.push_back(s);
    endfunction

    function automatic void push_r(input int ch, input int r, input logic [31:0] v,
                                   input bit ck_q, input logic q, input string nm);
        step_t s;
        s.is_wr = 1'b0; s.a = AW'(ch * 4 + r); s.v = v;
        s.q = q; s.ck_q = ck_q; s.nm = nm;
        sb.push_back(s);
    endfunction

    task automatic bus_wr(input logic [AW-1:0] a, input logic [31:0] v);
        mem_read   = 1'b0;
        mem_write  = 1'b1;
        address    = a;
        write_data = v;
        @(negedge clk);
        mem_write  = 1'b0;
    endtask

    task automatic bus_rd(input logic [AW-1:0] a, output logic [31:0] d, output logic q);
        mem_write = 1'b0;
        mem_read  = 1'b1;
        address   = a;
        #1;
        d = read_data;
        q = irq;
        @(negedge clk);
        mem_read  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic q; step_t s;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_r(0, 0, 32'h0, 1, 1'b0, "rst_th0");
        push_r(0, 1, 32'h0, 0, 1'b0, "rst_tl0");
        push_r(0, 2, 32'h0, 1, 1'b0, "rst_tcon0");
        push_r(4, 1, 32'h0, 0, 1'b0, "rst_tl4");
        push_r(4, 3, 32'h0, 0, 1'b0, "rst_psc4");
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (s.is_wr) bus_wr(s.a, s.v);
            else begin
                bus_rd(s.a, d, q);
                vectors++;
                if (d !== s.v) begin miscompares++; $display("FAIL %s: read_data=%h expected %h", s.nm, d, s.v); end
                if (s.ck_q) begin vectors++; if (q !== s.q) begin miscompares++; $display("FAIL %s irq: got %b expected %b", s.nm, q, s.q); end end
            end
        end
    endtask

    task automatic test_autoreload();
        logic [31:0] d; logic q; step_t s;
        logic [31:0] seq [7];
        seq = '{32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF,
                32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE};
        push_w(0, 0, 32'hFFFFFFFC);
        push_w(0, 1, 32'hFFFFFFFC);
        push_w(0, 2, 32'h3);
        for (int i = 0; i < 7; i++)
            push_r(0, 1, seq[i], 1, (i >= 4), $sformatf("reload_tl%0d", i));
        push_r(0, 2, 32'h7, 1, 1'b1, "reload_tcon");
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (s.is_wr) bus_wr(s.a, s.v);
            else begin
                bus_rd(s.a, d, q);
                vectors++;
                if (d !== s.v) begin miscompares++; $display("FAIL %s: read_data=%h expected %h", s.nm, d, s.v); end
                if (s.ck_q) begin vectors++; if (q !== s.q) begin miscompares++; $display("FAIL %s irq: got %b expected %b", s.nm, q, s.q); end end
            end
        end
    endtask

    task automatic test_if_clear();
        logic [31:0] d; logic q; step_t s;
        push_w(0, 2, 32'h7);
        push_r(0, 2, 32'h3, 1, 1'b0, "ifclr_tcon");
        push_r(0, 1, 32'hFFFFFFFD, 0, 1'b0, "ifclr_tl_a");
        push_r(0, 1, 32'hFFFFFFFE, 0, 1'b0, "ifclr_tl_b");
        push_w(0, 2, 32'h7);
        push_r(0, 1, 32'hFFFFFFFF, 0, 1'b0, "ifclr_suppress");
        push_r(0, 2, 32'h7, 1, 1'b1, "ifclr_set_wins");
        push_w(0, 2, 32'h4);
        push_r(0, 2, 32'h0, 1, 1'b0, "ifclr_stop");
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (s.is_wr) bus_wr(s.a, s.v);
            else begin
                bus_rd(s.a, d, q);
                vectors++;
                if (d !== s.v) begin miscompares++; $display("FAIL %s: read_data=%h expected %h", s.nm, d, s.v); end
                if (s.ck_q) begin vectors++; if (q !== s.q) begin miscompares++; $display("FAIL %s irq: got %b expected %b", s.nm, q, s.q); end end
            end
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] d; logic q; step_t s;
        push_w(1, 0, 32'h00001234);
        push_w(1, 1, 32'hFFFFFFFE);
        push_w(1, 2, 32'hB);
        push_r(1, 1, 32'hFFFFFFFE, 1, 1'b0, "os_tl0");
        push_r(1, 1, 32'hFFFFFFFF, 1, 1'b0, "os_tl1");
        push_r(1, 1, 32'h00001234, 1, 1'b1, "os_reload");
        push_r(1, 2, 32'hE, 1, 1'b1, "os_tcon");
        push_r(1, 1, 32'h00001234, 0, 1'b0, "os_frozen_a");
        push_r(1, 1, 32'h00001234, 0, 1'b0, "os_frozen_b");
        push_w(1, 2, 32'h4);
        push_r(1, 2, 32'h0, 1, 1'b0, "os_clear");
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (s.is_wr) bus_wr(s.a, s.v);
            else begin
                bus_rd(s.a, d, q);
                vectors++;
                if (d !== s.v) begin miscompares++; $display("FAIL %s: read_data=%h expected %h", s.nm, d, s.v); end
                if (s.ck_q) begin vectors++; if (q !== s.q) begin miscompares++; $display("FAIL %s irq: got %b expected %b", s.nm, q, s.q); end end
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] d; logic q; step_t s;
        push_w(2, 1, 32'd100);
        push_w(3, 1, 32'd200);
        push_w(2, 2, 32'h1);
        push_w(3, 2, 32'h1);
        push_r(3, 1, 32'd200, 0, 1'b0, "col_ch3_a");
        push_r(2, 1, 32'd102, 0, 1'b0, "col_ch2_a");
        push_w(2, 1, 32'd5);
        push_r(2, 1, 32'd5,   0, 1'b0, "col_ch2_wr");
        push_r(3, 1, 32'd204, 0, 1'b0, "col_ch3_undisturbed");
        push_r(2, 1, 32'd7,   0, 1'b0, "col_ch2_b");
        push_w(2, 2, 32'h0);
        push_r(2, 1, 32'd8, 0, 1'b0, "col_en0_nocount");
        push_r(2, 2, 32'h0, 0, 1'b0, "col_en0_tcon");
        push_w(3, 2, 32'h0);
        push_w(2, 1, 32'hFFFFFFFF);
        push_w(2, 2, 32'h1);
        push_w(2, 0, 32'h55);
        push_r(2, 1, 32'h55, 0, 1'b0, "col_th_on_ovf");
        push_r(2, 0, 32'h55, 0, 1'b0, "col_th_value");
        push_w(2, 2, 32'h0);
        push_r(2, 1, 32'h57, 1, 1'b0, "col_th_stop");
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (s.is_wr) bus_wr(s.a, s.v);
            else begin
                bus_rd(s.a, d, q);
                vectors++;
                if (d !== s.v) begin miscompares++; $display("FAIL %s: read_data=%h expected %h", s.nm, d, s.v); end
                if (s.ck_q) begin vectors++; if (q !== s.q) begin miscompares++; $display("FAIL %s irq: got %b expected %b", s.nm, q, s.q); end end
            end
        end
    endtask

    task automatic test_prescale();
        logic [31:0] d; logic q; step_t s;
        logic [31:0] seq [7];
`ifdef MULTI_TIMER_PRESCALE_EN
        seq = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd2};
`else
        seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
`endif
        push_w(3, 3, 32'h2);
        push_w(3, 1, 32'h0);
        push_w(3, 2, 32'h1);
        for (int i = 0; i < 7; i++)
            push_r(3, 1, seq[i], 0, 1'b0, $sformatf("psc_tl%0d", i));
`ifdef MULTI_TIMER_PRESCALE_EN
        push_r(3, 3, 32'h2, 0, 1'b0, "psc_reg");
`else
        push_r(3, 3, 32'h0, 0, 1'b0, "psc_reg_absent");
`endif
        push_w(3, 2, 32'h0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            if (s.is_wr) bus_wr(s.a, s.v);
            else begin
                bus_rd(s.a, d, q);
                vectors++;
                if (d !== s.v) begin miscompares++; $display("FAIL %s: read_data=%h expected %h", s.nm, d, s.v); end
                if (s.ck_q) begin vectors++; if (q !== s.q) begin miscompares++; $display("FAIL %s irq: got %b expected %b", s.nm, q, s.q); end end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic q; step_t s;
        push_w(0, 1, 32'hFFFFFFFF);
        push_w(0, 2, 32'h3);
        push_r(0, 2, 32'h3, 1, 1'b0, "mid_pre");
        push_r(0, 2, 32'h7, 1, 1'b1, "mid_irq");
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 1) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                push_r(0, 1, 32'h0, 1, 1'b0, "mid_tl");
                push_r(0, 1, 32'h0, 0, 1'b0, "mid_tl_held");
                push_r(0, 0, 32'h0, 0, 1'b0, "mid_th");
                push_r(0, 2, 32'h0, 1, 1'b0, "mid_tcon");
                push_r(1, 0, 32'h0, 0, 1'b0, "mid_th1");
                push_w(0, 0, 32'h0000ABCD);
                push_w(5, 1, 32'h99);
                push_w(7, 0, 32'h77);
                push_r(5, 1, 32'h0, 0, 1'b0, "unmapped_ch5");
                push_r(7, 0, 32'h0, 0, 1'b0, "unmapped_ch7");
                push_r(0, 0, 32'h0000ABCD, 0, 1'b0, "mapped_th0");
                push_r(0, 1, 32'h0, 0, 1'b0, "no_alias_tl0");
            end
            while (sb.size() > 0) begin
                s = sb.pop_front();
                if (s.is_wr) bus_wr(s.a, s.v);
                else begin
                    bus_rd(s.a, d, q);
                    vectors++;
                    if (d !== s.v) begin miscompares++; $display("FAIL %s: read_data=%h expected %h", s.nm, d, s.v); end
                    if (s.ck_q) begin vectors++; if (q !== s.q) begin miscompares++; $display("FAIL %s irq: got %b expected %b", s.nm, q, s.q); end end
                end
            end
        end
        mem_read = 1'b0;
        address  = AW'(0);
        #1;
        vectors++;
        if (read_data !== 32'h0) begin
            miscompares++;
            $display("FAIL no_strobe: read_data=%h expected %h", read_data, 32'h0);
        end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_autoreload();
        test_if_clear();
        test_oneshot();
        test_collision();
        test_prescale();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
